branch_judge_unit: RTL and testbench
====================================

Name: branch_judge_unit

Overview:
Registered, parametrised successor to the combinational jump-condition decoder. Holds the S/Z/C/V flag register, evaluates a 4-bit condition code (16 conditions) against it, and issues a single-cycle PC load with target address. After a taken branch it drives a multi-cycle pipeline flush, refusing new branch requests until the flush completes, and counts taken branches. Sits between the execute-stage flag producer and the PC/fetch logic.

Parameters:
ADDR_W, 16, width of branch target and pc_target
FLUSH_CYCLES, 2, cycles flush is held after a taken branch; 0 means no flush and never busy
FWD_FLAGS, 1, 1 means a branch in the same cycle as flag_we uses flag_in; 0 means it uses the previously registered flags
CNT_W, 16, width of taken-branch counter

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  synchronous active-low reset
flag_we  in  1  load flag_in into the flag register
flag_in  in  4  {S,Z,C,V} from the ALU
br_valid  in  1  branch request, with br_cond and br_target
br_cond  in  4  condition code
br_target  in  ADDR_W  branch destination
br_ready  out  1  high when a request can be accepted (= not busy)
pc_load  out  1  one-cycle pulse, load PC
pc_target  out  ADDR_W  target, valid while pc_load is high; holds its last value otherwise
flush  out  1  pipeline flush
busy  out  1  flush sequence in progress
flags_q  out  4  registered {S,Z,C,V}
taken_count  out  CNT_W  number of taken branches

Behaviour:
- Reset (rst_n low at a clk edge): flags_q=0, pc_load=0, pc_target=0, flush=0, busy=0, taken_count=0, FSM to IDLE. Reset has priority over all other inputs, including mid-flush.
- Flag register: on flag_we, flags_q <= flag_in at the next edge.
- Eval flags: flag_in when FWD_FLAGS=1 and flag_we is high in the same cycle; flags_q otherwise.
- Condition codes (S,Z,C,V = eval flags):
  - 0 EQ: Z
  - 1 LT: S^V
  - 2 LE: Z|(S^V)
  - 3 NE: !Z
  - 4 GE: !(S^V)
  - 5 GT: !Z&!(S^V)
  - 6 CS: C
  - 7 CC: !C
  - 8 MI: S
  - 9 PL: !S
  - 10 VS: V
  - 11 VC: !V
  - 12 HI: C&!Z
  - 13 LS: !C|Z
  - 14 AL: 1
  - 15 NV: 0
  - Codes 0-3 keep their legacy meaning.
- Accept: br_valid & br_ready at edge t. br_ready is combinationally !busy.
- Taken accept:
  - Cycle after t: pc_load=1 and pc_target=br_target.
  - taken_count increments, wrapping at 2^CNT_W.
  - If FLUSH_CYCLES>0: FSM goes IDLE->FLUSH. flush=1 and busy=1 for exactly FLUSH_CYCLES cycles starting the cycle after t (same cycle as pc_load). The down-counter is loaded with FLUSH_CYCLES-1; FSM returns to IDLE when the counter is 0.
- Not-taken accept: no pc_load, no flush, FSM stays IDLE, counter unchanged.
- br_valid while busy: request ignored (dropped), no side effects. The requester must hold until br_ready.
- FLUSH_CYCLES=0: FSM never leaves IDLE; back-to-back taken branches give back-to-back pc_load pulses.
- Latency: request to pc_load is 1 cycle, registered. All outputs are registered except br_ready.
- pc_load is never high for 2 consecutive cycles when FLUSH_CYCLES>=1.

Test Plan:
- Reset with FLUSH_CYCLES=2: assert rst_n=0 for 2 cycles -> all outputs 0, br_ready=1.
- Legacy conditions: flags_q={S,Z,C,V}=0100, br_cond=0 with target 0x1234 -> pc_load pulse 1 cycle later, pc_target=0x1234, flush high 2 cycles, taken_count=1. Then br_cond=3 -> no pc_load.
- Full sweep: for all 16 flag values x 16 condition codes -> pc_load matches the condition table. Codes 14 and 15 are always taken and never taken respectively.
- Forwarding: flags_q=0000; in the same cycle apply flag_we=1, flag_in=0100, br_cond=0. FWD_FLAGS=1 -> taken. FWD_FLAGS=0 -> not taken, and flags_q=0100 afterwards.
- Busy drop: taken branch, then br_valid with br_cond=14 during both flush cycles -> br_ready=0, ignored. Next request, after busy falls, is accepted. taken_count=2 total.
- Reset mid-flush (FLUSH_CYCLES=4): rst_n=0 on the 2nd flush cycle -> flush=0, busy=0, taken_count=0 at the next cycle. Also check FLUSH_CYCLES=0 with two consecutive AL requests -> two consecutive pc_load pulses, flush never asserted.

Source files
------------

// File: rtl/branch_judge_unit_if.sv
// rtl/branch_judge_unit_if.sv - flag/branch request and PC-load/flush bundle
interface branch_judge_unit_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
);
    logic              flag_we;
    logic [3:0]        flag_in;
    logic              br_valid;
    logic [3:0]        br_cond;
    logic [ADDR_W-1:0] br_target;
    logic              br_ready;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_target;
    logic              flush;
    logic              busy;
    logic [3:0]        flags_q;
    logic [CNT_W-1:0]  taken_count;

    modport master (
        output flag_we, flag_in, br_valid, br_cond, br_target,
        input  br_ready, pc_load, pc_target, flush, busy, flags_q, taken_count
    );

    modport slave (
        input  flag_we, flag_in, br_valid, br_cond, br_target,
        output br_ready, pc_load, pc_target, flush, busy, flags_q, taken_count
    );
endinterface

// File: rtl/branch_judge_unit.sv
// rtl/branch_judge_unit.sv - registered branch condition judge with PC load and pipeline flush
module branch_judge_unit #(
    parameter int ADDR_W       = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int FWD_FLAGS    = 1,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    branch_judge_unit_if.slave  bus
);
    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] FLUSH_LOAD = CW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    logic [0:0]        state;
    logic [CW-1:0]     flush_cnt;
    logic [3:0]        flags_r;
    logic              pc_load_r;
    logic [ADDR_W-1:0] target_r;
    logic [CNT_W-1:0]  count_r;

    logic [3:0] eval_flags;
    logic       s, z, c, v;
    logic       cond_true;
    logic       busy_w;
    logic       taken;

    // Forwarding lets a compare-and-branch pair resolve without a bubble.
    assign eval_flags = ((FWD_FLAGS != 0) && bus.flag_we) ? bus.flag_in : flags_r;
    assign {s, z, c, v} = eval_flags;

    always_comb begin
        cond_true = 1'b0;
        case (bus.br_cond)
            4'd0:    cond_true = z;
            4'd1:    cond_true = s ^ v;
            4'd2:    cond_true = z | (s ^ v);
            4'd3:    cond_true = !z;
            4'd4:    cond_true = !(s ^ v);
            4'd5:    cond_true = !z & !(s ^ v);
            4'd6:    cond_true = c;
            4'd7:    cond_true = !c;
            4'd8:    cond_true = s;
            4'd9:    cond_true = !s;
            4'd10:   cond_true = v;
            4'd11:   cond_true = !v;
            4'd12:   cond_true = c & !z;
            4'd13:   cond_true = !c | z;
            4'd14:   cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign busy_w = (state == S_FLUSH);
    assign taken  = bus.br_valid && !busy_w && cond_true;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            flush_cnt <= '0;
            flags_r   <= 4'b0;
            pc_load_r <= 1'b0;
            target_r  <= '0;
            count_r   <= '0;
        end else begin
            if (bus.flag_we) begin
                flags_r <= bus.flag_in;
            end
            pc_load_r <= taken;
            if (taken) begin
                target_r <= bus.br_target;
                count_r  <= count_r + CNT_W'(1);
            end
            case (state)
                S_IDLE: begin
                    if (taken && (FLUSH_CYCLES > 0)) begin
                        state     <= S_FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                    end
                end
                default: begin
                    if (flush_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - CW'(1);
                    end
                end
            endcase
        end
    end

    assign bus.br_ready    = !busy_w;
    assign bus.busy        = busy_w;
    assign bus.flush       = busy_w;
    assign bus.pc_load     = pc_load_r;
    assign bus.pc_target   = target_r;
    assign bus.flags_q     = flags_r;
    assign bus.taken_count = count_r;
endmodule

// File: tb/tb_branch_judge_unit.sv
// tb/tb_branch_judge_unit.sv - self-checking bench for branch_judge_unit across four configurations
module tb_branch_judge_unit;
    logic        clk;
    logic        rst_n;
    logic        flag_we;
    logic [3:0]  flag_in;
    logic        br_valid;
    logic [3:0]  br_cond;
    logic [15:0] br_target;

    int total = 0;
    int bad   = 0;

    // d0: FLUSH=2 FWD=1, d1: FLUSH=2 FWD=0, d2: FLUSH=4 FWD=1, d3: FLUSH=0 FWD=1
    branch_judge_unit_if #(.ADDR_W(16), .CNT_W(16)) if0 ();
    branch_judge_unit_if #(.ADDR_W(16), .CNT_W(16)) if1 ();
    branch_judge_unit_if #(.ADDR_W(16), .CNT_W(16)) if2 ();
    branch_judge_unit_if #(.ADDR_W(16), .CNT_W(16)) if3 ();

    assign {if0.flag_we, if0.flag_in, if0.br_valid, if0.br_cond, if0.br_target} = {flag_we, flag_in, br_valid, br_cond, br_target};
    assign {if1.flag_we, if1.flag_in, if1.br_valid, if1.br_cond, if1.br_target} = {flag_we, flag_in, br_valid, br_cond, br_target};
    assign {if2.flag_we, if2.flag_in, if2.br_valid, if2.br_cond, if2.br_target} = {flag_we, flag_in, br_valid, br_cond, br_target};
    assign {if3.flag_we, if3.flag_in, if3.br_valid, if3.br_cond, if3.br_target} = {flag_we, flag_in, br_valid, br_cond, br_target};

    branch_judge_unit #(.ADDR_W(16), .FLUSH_CYCLES(2), .FWD_FLAGS(1), .CNT_W(16)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    branch_judge_unit #(.ADDR_W(16), .FLUSH_CYCLES(2), .FWD_FLAGS(0), .CNT_W(16)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    branch_judge_unit #(.ADDR_W(16), .FLUSH_CYCLES(4), .FWD_FLAGS(1), .CNT_W(16)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    branch_judge_unit #(.ADDR_W(16), .FLUSH_CYCLES(0), .FWD_FLAGS(1), .CNT_W(16)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          fc[4] = '{2, 2, 4, 0};
    bit          fw[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int          m_busy[4];
    logic [3:0]  m_flags[4];
    logic        m_pcl[4];
    logic [15:0] m_tgt[4];
    logic [15:0] m_cnt[4];

    function automatic bit cond_holds(logic [3:0] code, logic [3:0] f);
        bit s, z, c, v, lt;
        {s, z, c, v} = f;
        lt = (s != v);
        case (code)
            4'd0:  return z;
            4'd1:  return lt;
            4'd2:  return z || lt;
            4'd3:  return !z;
            4'd4:  return !lt;
            4'd5:  return !z && !lt;
            4'd6:  return c;
            4'd7:  return !c;
            4'd8:  return s;
            4'd9:  return !s;
            4'd10: return v;
            4'd11: return !v;
            4'd12: return c && !z;
            4'd13: return !c || z;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(int id, logic pcl, logic [15:0] tgt, logic fl, logic bs,
                             logic rdy, logic [3:0] fq, logic [15:0] cnt);
        check($sformatf("d%0d.pc_load", id), 32'(pcl), 32'(m_pcl[id]));
        check($sformatf("d%0d.pc_target", id), 32'(tgt), 32'(m_tgt[id]));
        check($sformatf("d%0d.flush", id), 32'(fl), 32'(m_busy[id] > 0));
        check($sformatf("d%0d.busy", id), 32'(bs), 32'(m_busy[id] > 0));
        check($sformatf("d%0d.br_ready", id), 32'(rdy), 32'(m_busy[id] == 0));
        check($sformatf("d%0d.flags_q", id), 32'(fq), 32'(m_flags[id]));
        check($sformatf("d%0d.taken_count", id), 32'(cnt), 32'(m_cnt[id]));
    endtask

    // Advance one clock: update the model from the current inputs, then compare every DUT.
    task automatic step();
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                m_busy[i] = 0; m_flags[i] = 4'b0; m_pcl[i] = 1'b0; m_tgt[i] = 16'h0; m_cnt[i] = 16'h0;
            end else begin
                logic [3:0] ef;
                bit tk;
                ef = (fw[i] && flag_we) ? flag_in : m_flags[i];
                tk = br_valid && (m_busy[i] == 0) && cond_holds(br_cond, ef);
                if (flag_we) m_flags[i] = flag_in;
                m_pcl[i] = tk;
                if (tk) begin
                    m_tgt[i]  = br_target;
                    m_cnt[i]  = m_cnt[i] + 16'd1;
                    m_busy[i] = fc[i];
                end else if (m_busy[i] > 0) begin
                    m_busy[i]--;
                end
            end
        end
        @(posedge clk);
        #1;
        check_dut(0, if0.pc_load, if0.pc_target, if0.flush, if0.busy, if0.br_ready, if0.flags_q, if0.taken_count);
        check_dut(1, if1.pc_load, if1.pc_target, if1.flush, if1.busy, if1.br_ready, if1.flags_q, if1.taken_count);
        check_dut(2, if2.pc_load, if2.pc_target, if2.flush, if2.busy, if2.br_ready, if2.flags_q, if2.taken_count);
        check_dut(3, if3.pc_load, if3.pc_target, if3.flush, if3.busy, if3.br_ready, if3.flags_q, if3.taken_count);
    endtask

    task automatic idle_inputs();
        flag_we = 1'b0; br_valid = 1'b0; flag_in = 4'h0; br_cond = 4'h0; br_target = 16'h0;
    endtask

    task automatic wait_idle();
        idle_inputs();
        for (int k = 0; k < 10 && (if0.busy || if1.busy || if2.busy || if3.busy); k++) step();
        check("wait_idle_bound", 32'(if0.busy || if1.busy || if2.busy || if3.busy), 32'd0);
    endtask

    task automatic do_reset(int cycles);
        idle_inputs();
        rst_n = 1'b0;
        for (int k = 0; k < cycles; k++) step();
        rst_n = 1'b1;
    endtask

    task automatic load_flags(logic [3:0] f);
        idle_inputs();
        flag_we = 1'b1; flag_in = f;
        step();
        flag_we = 1'b0;
    endtask

    int order[256];

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        // Reset: everything cleared, request accepted
        do_reset(2);
        check("rst.pc_load", 32'(if0.pc_load), 32'd0);
        check("rst.pc_target", 32'(if0.pc_target), 32'd0);
        check("rst.flush", 32'(if0.flush), 32'd0);
        check("rst.busy", 32'(if0.busy), 32'd0);
        check("rst.flags_q", 32'(if0.flags_q), 32'd0);
        check("rst.taken_count", 32'(if0.taken_count), 32'd0);
        check("rst.br_ready", 32'(if0.br_ready), 32'd1);

        // Legacy EQ taken with Z set, then NE not taken
        load_flags(4'b0100);
        br_valid = 1'b1; br_cond = 4'd0; br_target = 16'h1234;
        step();
        idle_inputs();
        check("legacy.eq_pc_load", 32'(if0.pc_load), 32'd1);
        check("legacy.eq_target", 32'(if0.pc_target), 32'h1234);
        check("legacy.flush1", 32'(if0.flush), 32'd1);
        check("legacy.count", 32'(if0.taken_count), 32'd1);
        step();
        check("legacy.flush2", 32'(if0.flush), 32'd1);
        check("legacy.no_double_pcl", 32'(if0.pc_load), 32'd0);
        step();
        check("legacy.flush_end", 32'(if0.flush), 32'd0);
        wait_idle();
        br_valid = 1'b1; br_cond = 4'd3; br_target = 16'h5678;
        step();
        idle_inputs();
        check("legacy.ne_pc_load", 32'(if0.pc_load), 32'd0);
        check("legacy.ne_target_hold", 32'(if0.pc_target), 32'h1234);

        // Full sweep of 16 flag values x 16 condition codes in shuffled order
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(i, 0));
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 256; i++) begin
            logic [3:0] f, cc;
            f  = 4'(order[i] >> 4);
            cc = 4'(order[i]);
            wait_idle();
            load_flags(f);
            br_valid = 1'b1; br_cond = cc; br_target = 16'($urandom);
            step();
            idle_inputs();
            if (cc == 4'd14) check("sweep.al_taken", 32'(if0.pc_load), 32'd1);
            if (cc == 4'd15) check("sweep.nv_never", 32'(if0.pc_load), 32'd0);
        end

        // Forwarding: flag write and EQ branch in the same cycle
        wait_idle();
        load_flags(4'b0000);
        flag_we = 1'b1; flag_in = 4'b0100; br_valid = 1'b1; br_cond = 4'd0; br_target = 16'hBEEF;
        step();
        idle_inputs();
        check("fwd1.taken", 32'(if0.pc_load), 32'd1);
        check("fwd0.not_taken", 32'(if1.pc_load), 32'd0);
        check("fwd0.flags_after", 32'(if1.flags_q), 32'b0100);

        // Busy drop: AL held through both flush cycles is ignored, then accepted
        wait_idle();
        do_reset(1);
        br_valid = 1'b1; br_cond = 4'd14; br_target = 16'h0A0A;
        step();
        check("drop.first_pcl", 32'(if0.pc_load), 32'd1);
        check("drop.ready_c1", 32'(if0.br_ready), 32'd0);
        br_target = 16'h0B0B;
        step();
        check("drop.ready_c2", 32'(if0.br_ready), 32'd0);
        check("drop.no_pcl_c2", 32'(if0.pc_load), 32'd0);
        step();
        check("drop.ready_back", 32'(if0.br_ready), 32'd1);
        check("drop.no_pcl_c3", 32'(if0.pc_load), 32'd0);
        step();
        idle_inputs();
        check("drop.second_pcl", 32'(if0.pc_load), 32'd1);
        check("drop.second_target", 32'(if0.pc_target), 32'h0B0B);
        check("drop.count", 32'(if0.taken_count), 32'd2);

        // Reset in the middle of a 4-cycle flush
        wait_idle();
        br_valid = 1'b1; br_cond = 4'd14; br_target = 16'h4444;
        step();
        idle_inputs();
        step();
        check("midrst.flush_c2", 32'(if2.flush), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst.flush", 32'(if2.flush), 32'd0);
        check("midrst.busy", 32'(if2.busy), 32'd0);
        check("midrst.count", 32'(if2.taken_count), 32'd0);

        // FLUSH_CYCLES=0: back-to-back AL gives back-to-back pc_load
        br_valid = 1'b1; br_cond = 4'd14; br_target = 16'h0101;
        step();
        check("f0.pcl1", 32'(if3.pc_load), 32'd1);
        br_target = 16'h0202;
        step();
        idle_inputs();
        check("f0.pcl2", 32'(if3.pc_load), 32'd1);
        check("f0.target2", 32'(if3.pc_target), 32'h0202);
        check("f0.no_flush", 32'(if3.flush), 32'd0);

        // Random traffic with occasional resets, all checked against the model
        for (int n = 0; n < 400; n++) begin
            rst_n     = ($urandom_range(49, 0) != 0);
            flag_we   = 1'($urandom);
            flag_in   = 4'($urandom);
            br_valid  = 1'($urandom);
            br_cond   = 4'($urandom);
            br_target = 16'($urandom);
            step();
        end
        rst_n = 1'b1;
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
